gf180mcu_ocd_io__bi_bank_ctrl: RTL and testbench
================================================

# gf180mcu_ocd_io__bi_bank_ctrl

Parametrised, clocked control bank for NCH bidirectional pad cells of the bi_t family. It holds per-channel mode and drive configuration and drives each pad cell's A/OE/IE/PU/PD/PDRV/SL/CS pins from registers. Direction changes are sequenced break-before-make, and pad input Y is synchronised and edge-detected into sticky interrupt flags. It sits between the core-side register file and the padring.

## Interface
Parameters:
- NCH, 8, number of pad channels (1..32)
- SYNC_STAGES, 2, synchroniser depth on PAD_Y (>=2)
- TURN_CYC, 2, drain cycles on a mode change (>=1)

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RESETN  input  1  reset; synchronous, active-low
- CFG_WE  input  1  config write strobe
- CFG_SEL  input  clog2(NCH)  target channel; values >=NCH are ignored
- CFG_DATA  input  8  [2:0] MODE, [4:3] PDRV{1,0}, [5] SL, [6] CS, [7] IRQ_EN
- OUT_DATA  input  NCH  core output value per channel
- IRQ_CLR  input  NCH  per-channel flag clear, 1-cycle pulse
- IN_DATA  output  NCH  synchronised pad input
- IRQ_FLAG  output  NCH  sticky rising-edge flags
- IRQ  output  1  OR of IRQ_FLAG
- BUSY  output  NCH  channel is in DRAIN
- PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD, PAD_PDRV0, PAD_PDRV1, PAD_SL, PAD_CS  output  NCH each  to pad cell pins
- PAD_Y  input  NCH  from pad cell Y

## Operation
- Modes (MODE field):
  - 0: disabled; all pad controls 0.
  - 1: input; IE=1.
  - 2: input with pull-up; IE=1, PU=1.
  - 3: input with pull-down; IE=1, PD=1.
  - 4: push-pull; OE=1, IE=1, A=OUT_DATA.
  - 5: open-drain; A=0, OE=~OUT_DATA, IE=1.
  - 6: output without readback; OE=1, IE=0, A=OUT_DATA.
  - 7: decoded as 0.
- PU and PD are never both 1. OE=1 never coincides with PU or PD.
- Per-channel state machine, states IDLE, DRAIN, SETTLE:
  - Write with MODE equal to the pending mode: PDRV/SL/CS/IRQ_EN update directly. No state change.
  - Write with a different MODE, from any state: pending mode latched, counter loaded with TURN_CYC, state goes to DRAIN.
  - DRAIN: OE=0, PU=0, PD=0; IE and A hold their previous values. Counter decrements each cycle. At 0, the mode is applied and state goes to SETTLE.
  - A write during DRAIN restarts the count. Last write wins.
  - SETTLE lasts SYNC_STAGES cycles, then state goes to IDLE.
  - IRQ detection runs only in IDLE. The edge history register reloads from IN_DATA on every cycle outside IDLE.
- Edge flag: set when IN_DATA rises, in IDLE, with IRQ_EN=1 and PAD_IE=1. IRQ_CLR clears the flag. Set wins over a simultaneous clear.
- Reset mid-DRAIN aborts the sequence. The pending mode is discarded and all channels return to mode 0.

## Timing
- Reset values:
  - All PAD_* outputs, IN_DATA, IRQ_FLAG, IRQ and BUSY are 0.
  - Every channel is in mode 0, state IDLE, with config fields 0.
- OUT_DATA -> PAD_A (or PAD_OE in mode 5): 1 cycle.
- Non-mode config write in cycle t: pad pins reflect it at t+1.
- Mode-change write in cycle t:
  - BUSY=1 and drained outputs during t+1..t+TURN_CYC.
  - New mode on pads at t+TURN_CYC+1, with BUSY=0.
  - SETTLE through t+TURN_CYC+SYNC_STAGES.
  - IDLE from t+TURN_CYC+SYNC_STAGES+1.
- PAD_Y -> IN_DATA: SYNC_STAGES cycles.
- IN_DATA rise -> IRQ_FLAG: +1 cycle. IRQ follows IRQ_FLAG combinationally.

## Test plan
- Reset: hold RESETN=0 for 3 cycles with random inputs -> all outputs 0 on the first cycle after release.
- Direction change, NCH=8, TURN_CYC=2: channel 3 in mode 4 with OUT_DATA[3]=1; write MODE=2 at t.
  - t+1, t+2: PAD_OE[3]=0, PAD_PU[3]=0, BUSY[3]=1.
  - t+3: PAD_IE[3]=1, PAD_PU[3]=1, BUSY[3]=0.
- Restart: second mode write to the same channel at t+1 -> DRAIN runs to t+3, and the second mode appears at t+4.
- Open-drain: mode 5, toggle OUT_DATA[0] 0->1 -> PAD_OE[0] goes 1->0 one cycle later; PAD_A[0] stays 0.
- IRQ:
  - Mode 1 with IRQ_EN=1, PAD_Y[5] 0->1 at t -> IN_DATA[5]=1 at t+2, IRQ_FLAG[5]=1 and IRQ=1 at t+3.
  - IRQ_CLR[5] pulsed together with a new rising edge -> flag stays 1.
- Masking: a PAD_Y edge during DRAIN or SETTLE -> no flag set.
- Out-of-range write: CFG_SEL >= NCH -> no channel changes.

Source files
------------

// File: rtl/gf180mcu_ocd_io__bi_bank_ctrl.sv
`default_nettype none
// gf180mcu_ocd_io__bi_bank_ctrl -- bi_t pad bank: per-channel mode/drive registers, break-before-make
// direction sequencing, pad input synchroniser and sticky rising-edge flags.  Rev 1.0
module gf180mcu_ocd_io__bi_bank_ctrl #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 2,
  localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            CFG_WE,
  input  logic [SELW-1:0] CFG_SEL,
  input  logic [7:0]      CFG_DATA,
  input  logic [NCH-1:0]  OUT_DATA,
  input  logic [NCH-1:0]  IRQ_CLR,
  output logic [NCH-1:0]  IN_DATA,
  output logic [NCH-1:0]  IRQ_FLAG,
  output logic            IRQ,
  output logic [NCH-1:0]  BUSY,
  output logic [NCH-1:0]  PAD_A,
  output logic [NCH-1:0]  PAD_OE,
  output logic [NCH-1:0]  PAD_IE,
  output logic [NCH-1:0]  PAD_PU,
  output logic [NCH-1:0]  PAD_PD,
  output logic [NCH-1:0]  PAD_PDRV0,
  output logic [NCH-1:0]  PAD_PDRV1,
  output logic [NCH-1:0]  PAD_SL,
  output logic [NCH-1:0]  PAD_CS,
  input  logic [NCH-1:0]  PAD_Y
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } ch_state_t;

  localparam int CNT_MAX = (TURN_CYC > SYNC_STAGES) ? TURN_CYC : SYNC_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] out_q;
  logic [NCH-1:0] in_prev_q;
  logic [NCH-1:0] flag_q;
  logic [NCH-1:0] ch_idle;
  logic [NCH-1:0] ch_irq_en;
  logic [NCH-1:0] rise;
  logic [2:0]     wr_mode;

  // Mode 7 is folded onto 0 so that it also compares equal to a pending "disabled".
  assign wr_mode = (CFG_DATA[2:0] == 3'd7) ? 3'd0 : CFG_DATA[2:0];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      out_q     <= '0;
      in_prev_q <= '0;
      flag_q    <= '0;
    end else begin
      sync_q[0] <= PAD_Y;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      out_q     <= OUT_DATA;
      in_prev_q <= IN_DATA;
      flag_q    <= rise | (flag_q & ~IRQ_CLR);
    end
  end

  assign IN_DATA  = sync_q[SYNC_STAGES-1];
  assign rise     = IN_DATA & ~in_prev_q & ch_idle & ch_irq_en & PAD_IE;
  assign IRQ_FLAG = flag_q;
  assign IRQ      = |flag_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [SELW-1:0] CH_SEL = SELW'(i);

    ch_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d, pend_q, pend_d;
    logic [1:0]    pdrv_q;
    logic          sl_q, cs_q, irq_en_q;
    logic          ie_hold_q, a_hold_q;
    logic          wr;
    logic          a, oe, ie, pu, pd;

    assign wr = CFG_WE && (CFG_SEL == CH_SEL);

    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        st_q      <= ST_IDLE;
        cnt_q     <= '0;
        mode_q    <= '0;
        pend_q    <= '0;
        pdrv_q    <= '0;
        sl_q      <= 1'b0;
        cs_q      <= 1'b0;
        irq_en_q  <= 1'b0;
        ie_hold_q <= 1'b0;
        a_hold_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        pend_q <= pend_d;
        if (wr) begin
          pdrv_q   <= CFG_DATA[4:3];
          sl_q     <= CFG_DATA[5];
          cs_q     <= CFG_DATA[6];
          irq_en_q <= CFG_DATA[7];
        end
        // Freeze IE/A as seen just before draining; restarts inside DRAIN keep the original values.
        if (st_q != ST_DRAIN) begin
          ie_hold_q <= ie;
          a_hold_q  <= a;
        end
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      pend_d = pend_q;
      a  = 1'b0;
      oe = 1'b0;
      ie = 1'b0;
      pu = 1'b0;
      pd = 1'b0;

      case (st_q)
        ST_DRAIN: begin
          if (cnt_q == CNT_ONE) begin
            st_d   = ST_SETTLE;
            cnt_d  = SETTLE_LD;
            mode_d = pend_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: cnt_d = '0;
      endcase

      if (wr && (wr_mode != pend_q)) begin
        pend_d = wr_mode;
        st_d   = ST_DRAIN;
        cnt_d  = TURN_LD;
      end

      case (mode_q)
        3'd1: ie = 1'b1;
        3'd2: begin ie = 1'b1; pu = 1'b1; end
        3'd3: begin ie = 1'b1; pd = 1'b1; end
        3'd4: begin oe = 1'b1; ie = 1'b1; a = out_q[i]; end
        3'd5: begin oe = ~out_q[i]; ie = 1'b1; end
        3'd6: begin oe = 1'b1; a = out_q[i]; end
        default: ;
      endcase

      if (st_q == ST_DRAIN) begin
        oe = 1'b0;
        pu = 1'b0;
        pd = 1'b0;
        ie = ie_hold_q;
        a  = a_hold_q;
      end
    end

    assign PAD_A[i]     = a;
    assign PAD_OE[i]    = oe;
    assign PAD_IE[i]    = ie;
    assign PAD_PU[i]    = pu;
    assign PAD_PD[i]    = pd;
    assign PAD_PDRV0[i] = (mode_q != 3'd0) & pdrv_q[0];
    assign PAD_PDRV1[i] = (mode_q != 3'd0) & pdrv_q[1];
    assign PAD_SL[i]    = (mode_q != 3'd0) & sl_q;
    assign PAD_CS[i]    = (mode_q != 3'd0) & cs_q;
    assign BUSY[i]      = (st_q == ST_DRAIN);
    assign ch_idle[i]   = (st_q == ST_IDLE);
    assign ch_irq_en[i] = irq_en_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_ocd_io__bi_bank_ctrl.sv
`default_nettype none
// Directed bench for gf180mcu_ocd_io__bi_bank_ctrl; expectations queue with a due cycle and are
// compared when the run reaches that cycle. A second NCH=5 instance covers out-of-range selects.
module tb_gf180mcu_ocd_io__bi_bank_ctrl;
  localparam int NCH = 8;

  logic           CLK      = 1'b0;
  logic           RESETN   = 1'b0;
  logic           CFG_WE   = 1'b0;
  logic [2:0]     CFG_SEL  = '0;
  logic [7:0]     CFG_DATA = '0;
  logic [NCH-1:0] OUT_DATA = '0;
  logic [NCH-1:0] IRQ_CLR  = '0;
  logic [NCH-1:0] PAD_Y    = '0;
  logic [NCH-1:0] IN_DATA, IRQ_FLAG, BUSY, PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD;
  logic [NCH-1:0] PAD_PDRV0, PAD_PDRV1, PAD_SL, PAD_CS;
  logic           IRQ;

  logic [2:0] sel2 = 3'd7;
  logic [4:0] in2, flag2, busy2, a2, oe2, ie2, pu2, pd2, d02, d12, sl2, cs2;
  logic       irq2;

  gf180mcu_ocd_io__bi_bank_ctrl #(.NCH(NCH), .SYNC_STAGES(2), .TURN_CYC(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_DATA(CFG_DATA),
    .OUT_DATA(OUT_DATA), .IRQ_CLR(IRQ_CLR), .IN_DATA(IN_DATA), .IRQ_FLAG(IRQ_FLAG), .IRQ(IRQ),
    .BUSY(BUSY), .PAD_A(PAD_A), .PAD_OE(PAD_OE), .PAD_IE(PAD_IE), .PAD_PU(PAD_PU), .PAD_PD(PAD_PD),
    .PAD_PDRV0(PAD_PDRV0), .PAD_PDRV1(PAD_PDRV1), .PAD_SL(PAD_SL), .PAD_CS(PAD_CS), .PAD_Y(PAD_Y)
  );

  gf180mcu_ocd_io__bi_bank_ctrl #(.NCH(5), .SYNC_STAGES(2), .TURN_CYC(2)) dut5 (
    .CLK(CLK), .RESETN(RESETN), .CFG_WE(CFG_WE), .CFG_SEL(sel2), .CFG_DATA(CFG_DATA),
    .OUT_DATA(5'h1f), .IRQ_CLR(5'h00), .IN_DATA(in2), .IRQ_FLAG(flag2), .IRQ(irq2),
    .BUSY(busy2), .PAD_A(a2), .PAD_OE(oe2), .PAD_IE(ie2), .PAD_PU(pu2), .PAD_PD(pd2),
    .PAD_PDRV0(d02), .PAD_PDRV1(d12), .PAD_SL(sl2), .PAD_CS(cs2), .PAD_Y(5'h00)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_A, S_OE, S_IE, S_PU, S_PD, S_PDRV0, S_PDRV1, S_SL, S_CS,
                    S_BUSY, S_IN, S_FLAG, S_IRQ, S_ALL, S_ALL2, S_OE2} sig_e;
  typedef struct {
    int    due;
    string tag;
    sig_e  sig;
    int    ch;
    logic  exp;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   ncomp = 0;
  int   nfail = 0;

  function automatic logic obs(input sig_e s, input int ch);
    case (s)
      S_A:     return PAD_A[ch];
      S_OE:    return PAD_OE[ch];
      S_IE:    return PAD_IE[ch];
      S_PU:    return PAD_PU[ch];
      S_PD:    return PAD_PD[ch];
      S_PDRV0: return PAD_PDRV0[ch];
      S_PDRV1: return PAD_PDRV1[ch];
      S_SL:    return PAD_SL[ch];
      S_CS:    return PAD_CS[ch];
      S_BUSY:  return BUSY[ch];
      S_IN:    return IN_DATA[ch];
      S_FLAG:  return IRQ_FLAG[ch];
      S_IRQ:   return IRQ;
      S_ALL:   return |{PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD, PAD_PDRV0, PAD_PDRV1,
                        PAD_SL, PAD_CS, IN_DATA, IRQ_FLAG, BUSY, IRQ};
      S_ALL2:  return |{a2, oe2, ie2, pu2, pd2, d02, d12, sl2, cs2, in2, flag2, busy2, irq2};
      S_OE2:   return oe2[ch];
      default: return 1'bx;
    endcase
  endfunction

  task automatic push_exp(input int d, input string tag, input sig_e s, input int ch, input logic e);
    sb.push_back('{due: cyc + d, tag: tag, sig: s, ch: ch, exp: e});
  endtask

  task automatic step();
    logic o;
    @(posedge CLK);
    #2;
    cyc++;
    CFG_WE  = 1'b0;
    IRQ_CLR = '0;
    sel2    = 3'($urandom_range(7, 5));
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        o = obs(sb[i].sig, sb[i].ch);
        ncomp++;
        assert (o === sb[i].exp) else begin
          nfail++;
          $error("FAIL %s ch%0d cycle %0d: observed %b expected %b", sb[i].tag, sb[i].ch, cyc, o, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input int ch, input logic [7:0] d);
    CFG_WE   = 1'b1;
    CFG_SEL  = 3'(ch);
    CFG_DATA = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    RESETN = 1'b0;
    repeat (3) begin
      CFG_WE = 1'($urandom); CFG_SEL = 3'($urandom); CFG_DATA = 8'($urandom);
      OUT_DATA = 8'($urandom); IRQ_CLR = 8'($urandom); PAD_Y = 8'($urandom);
      push_exp(1, "rst_hold", S_ALL, 0, 1'b0);
      step();
    end
    RESETN = 1'b1; CFG_WE = 1'b0; OUT_DATA = 8'($urandom); PAD_Y = 8'($urandom);
    push_exp(1, "rst_release", S_ALL, 0, 1'b0);
    step();
    OUT_DATA = '0; PAD_Y = '0;
    wait_n(4);

    // Channel 3 to push-pull with A=1
    OUT_DATA[3] = 1'b1;
    cfg(3, 8'h04);
    push_exp(1, "pp_busy", S_BUSY, 3, 1'b1);
    push_exp(3, "pp_oe", S_OE, 3, 1'b1);
    push_exp(3, "pp_a", S_A, 3, 1'b1);
    wait_n(6);

    // Direction change 4 -> 2 (pull-up input)
    cfg(3, 8'h02);
    for (int d = 1; d <= 2; d++) begin
      push_exp(d, "dc_oe_drain", S_OE, 3, 1'b0);
      push_exp(d, "dc_pu_drain", S_PU, 3, 1'b0);
      push_exp(d, "dc_busy", S_BUSY, 3, 1'b1);
    end
    push_exp(1, "dc_a_hold", S_A, 3, 1'b1);
    push_exp(1, "dc_ie_hold", S_IE, 3, 1'b1);
    push_exp(3, "dc_ie_new", S_IE, 3, 1'b1);
    push_exp(3, "dc_pu_new", S_PU, 3, 1'b1);
    push_exp(3, "dc_oe_new", S_OE, 3, 1'b0);
    push_exp(3, "dc_busy_end", S_BUSY, 3, 1'b0);
    wait_n(6);

    // Restart: second mode write one cycle after the first
    cfg(3, 8'h01);
    push_exp(1, "rs_pu_drain", S_PU, 3, 1'b0);
    push_exp(1, "rs_busy1", S_BUSY, 3, 1'b1);
    push_exp(2, "rs_busy2", S_BUSY, 3, 1'b1);
    push_exp(3, "rs_busy3", S_BUSY, 3, 1'b1);
    push_exp(3, "rs_oe3", S_OE, 3, 1'b0);
    push_exp(4, "rs_oe4", S_OE, 3, 1'b1);
    push_exp(4, "rs_busy4", S_BUSY, 3, 1'b0);
    push_exp(4, "rs_a4", S_A, 3, 1'b1);
    step();
    cfg(3, 8'h04);
    wait_n(6);

    // OUT_DATA follow-through and a drive-only config write
    OUT_DATA[3] = 1'b0;
    push_exp(1, "pp_data", S_A, 3, 1'b0);
    step();
    OUT_DATA[3] = 1'b1;
    cfg(3, 8'h54);
    push_exp(1, "nm_a", S_A, 3, 1'b1);
    push_exp(1, "nm_pdrv1", S_PDRV1, 3, 1'b1);
    push_exp(1, "nm_pdrv0", S_PDRV0, 3, 1'b0);
    push_exp(1, "nm_cs", S_CS, 3, 1'b1);
    push_exp(1, "nm_sl", S_SL, 3, 1'b0);
    push_exp(1, "nm_busy", S_BUSY, 3, 1'b0);
    push_exp(1, "nm_oe", S_OE, 3, 1'b1);
    step();

    // Open-drain on channel 0
    OUT_DATA[0] = 1'b0;
    cfg(0, 8'h05);
    push_exp(3, "od_oe_on", S_OE, 0, 1'b1);
    wait_n(5);
    OUT_DATA[0] = 1'b1;
    push_exp(1, "od_oe_off", S_OE, 0, 1'b0);
    push_exp(1, "od_a", S_A, 0, 1'b0);
    step();
    OUT_DATA[0] = 1'b0;
    push_exp(1, "od_oe_back", S_OE, 0, 1'b1);
    wait_n(3);

    // Edge flag on channel 5
    cfg(5, 8'h81);
    wait_n(6);
    PAD_Y[5] = 1'b1;
    push_exp(1, "irq_in_lat", S_IN, 5, 1'b0);
    push_exp(2, "irq_in", S_IN, 5, 1'b1);
    push_exp(2, "irq_flag_lat", S_FLAG, 5, 1'b0);
    push_exp(3, "irq_flag", S_FLAG, 5, 1'b1);
    push_exp(3, "irq_or", S_IRQ, 0, 1'b1);
    wait_n(4);
    IRQ_CLR[5] = 1'b1;
    push_exp(1, "irq_clr", S_FLAG, 5, 1'b0);
    push_exp(1, "irq_or_clr", S_IRQ, 0, 1'b0);
    step();
    PAD_Y[5] = 1'b0;
    wait_n(3);
    PAD_Y[5] = 1'b1;
    wait_n(2);
    IRQ_CLR[5] = 1'b1;
    push_exp(1, "irq_set_wins", S_FLAG, 5, 1'b1);
    step();
    IRQ_CLR[5] = 1'b1;
    push_exp(1, "irq_clr2", S_FLAG, 5, 1'b0);
    step();
    PAD_Y[5] = 1'b0;
    wait_n(3);

    // Edge arriving during DRAIN is masked
    cfg(5, 8'h82);
    PAD_Y[5] = 1'b1;
    push_exp(1, "mk_busy", S_BUSY, 5, 1'b1);
    push_exp(2, "mk_in", S_IN, 5, 1'b1);
    for (int d = 1; d <= 6; d++) push_exp(d, "mk_drain_flag", S_FLAG, 5, 1'b0);
    wait_n(7);

    // Edge arriving in the last SETTLE cycle is masked
    PAD_Y[5] = 1'b0;
    wait_n(3);
    cfg(5, 8'h81);
    push_exp(4, "ms_in", S_IN, 5, 1'b1);
    push_exp(5, "ms_flag5", S_FLAG, 5, 1'b0);
    push_exp(6, "ms_flag6", S_FLAG, 5, 1'b0);
    wait_n(2);
    PAD_Y[5] = 1'b1;
    wait_n(6);

    // Out-of-range selects on the 5-channel instance
    for (int k = 0; k < 3; k++) begin
      cfg(7, 8'h04 + 8'(k));
      push_exp(4, "oor_quiet", S_ALL2, 0, 1'b0);
      step();
    end
    wait_n(4);
    sel2 = 3'd4;
    cfg(6, 8'h06);
    push_exp(3, "inrange_oe", S_OE2, 4, 1'b1);
    wait_n(5);

    // Reset in the middle of DRAIN
    PAD_Y = '0;
    wait_n(3);
    cfg(3, 8'h06);
    push_exp(1, "rd_busy", S_BUSY, 3, 1'b1);
    step();
    RESETN = 1'b0;
    push_exp(1, "rd_rst", S_ALL, 0, 1'b0);
    step();
    RESETN = 1'b1;
    push_exp(1, "rd_rel", S_ALL, 0, 1'b0);
    push_exp(3, "rd_no_resume_oe", S_OE, 3, 1'b0);
    push_exp(3, "rd_no_resume_busy", S_BUSY, 3, 1'b0);
    push_exp(4, "rd_all", S_ALL, 0, 1'b0);
    push_exp(4, "rd_all2", S_ALL2, 0, 1'b0);
    wait_n(5);

    ncomp++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
